fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 82 ++++++++
 tb/tb_fetch_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC sequencing against a one-cycle-latency RAM,
// with a 2-entry output FIFO, credit-based issue and redirect flush.
module fetch_controller #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] mem_a,
  input  logic [31:0] mem_rd,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);

  logic [15:0] pc;
  logic        inflight;
  logic [15:0] tag;
  logic [1:0]  occ;
  logic [15:0] head_pc, tail_pc;
  logic [31:0] head_inst, tail_inst;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] credit;
  logic [1:0] push_idx;

  assign mem_a      = pc;
  assign inst_valid = (occ != 2'd0);
  assign inst       = inst_valid ? head_inst : 32'h0;
  assign inst_pc    = inst_valid ? head_pc : 16'h0;

  assign pop      = inst_valid & inst_ready;
  assign push     = inflight;
  // pop implies occ >= 1, so this never goes negative
  assign credit   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue    = enable & ~redirect & (credit < 3'd2);
  assign push_idx = occ - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      inflight  <= 1'b0;
      tag       <= 16'h0;
      occ       <= 2'd0;
      head_pc   <= 16'h0;
      head_inst <= 32'h0;
      tail_pc   <= 16'h0;
      tail_inst <= 32'h0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (pop) begin
        head_pc   <= tail_pc;
        head_inst <= tail_inst;
      end
      // later assignment wins over the shift when the push lands in the head slot
      if (push) begin
        if (push_idx == 2'd0) begin
          head_pc   <= tag;
          head_inst <= mem_rd;
        end else begin
          tail_pc   <= tag;
          tail_inst <= mem_rd;
        end
      end
      occ      <= occ + {1'b0, push} - {1'b0, pop};
      inflight <= issue;
      if (issue) begin
        tag <= pc;
        pc  <= pc + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: latency, backpressure, redirect,
// enable stall, PC wrap and asynchronous reset.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst, enable, redirect, inst_ready;
  logic [15:0] redirect_pc;
  logic [15:0] mem_a, mem_a2;
  logic [31:0] mem_rd, mem_rd2;
  logic        inst_valid, inst_valid2;
  logic [31:0] inst, inst2;
  logic [15:0] inst_pc, inst_pc2;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk(clk), .rst(rst), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_a(mem_a), .mem_rd(mem_rd),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  fetch_controller #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_a(mem_a2), .mem_rd(mem_rd2),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .inst_ready(inst_ready)
  );

  function automatic logic [31:0] ram(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0, a};
  endfunction

  always @(posedge clk) begin
    mem_rd  <= ram(mem_a);
    mem_rd2 <= ram(mem_a2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [15:0] pc);
    chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    chk({tag, "_pc"}, {16'h0, inst_pc}, {16'h0, pc});
    chk({tag, "_inst"}, inst, ram(pc));
  endtask

  initial begin
    logic [15:0] wpc;
    rst = 1'b1; enable = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; inst_ready = 1'b1;
    step(); step();
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", {16'h0, inst_pc}, 32'h0);
    chk("rst_mem_a", {16'h0, mem_a}, 32'h0);
    chk("rst_mem_a_wrap", {16'h0, mem_a2}, 32'h0000_FFFE);

    rst = 1'b0;
    step();
    chk("lat_valid", {31'h0, inst_valid}, 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk_word("stream", k[15:0]);
      wpc = 16'hFFFE + k[15:0];
      chk("wrap_pc", {16'h0, inst_pc2}, {16'h0, wpc});
      chk("wrap_inst", inst2, ram(wpc));
      step();
    end

    // backpressure: head stays at 5, PC frozen at 7
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_word("bp_hold", 16'd5);
      chk("bp_mem_a", {16'h0, mem_a}, 32'd7);
      step();
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_word("bp_drain", 16'd5 + k[15:0]);
      step();
    end

    // fill both entries, then redirect with a pop in the same cycle
    inst_ready = 1'b0;
    step();
    chk_word("pre_redir", 16'd9);
    redirect = 1'b1; redirect_pc = 16'h0040; inst_ready = 1'b1;
    step();
    redirect = 1'b0;
    chk("redir_valid", {31'h0, inst_valid}, 32'h0);
    chk("redir_mem_a", {16'h0, mem_a}, 32'h40);
    step();
    chk("redir_valid2", {31'h0, inst_valid}, 32'h0);
    chk("redir_mem_a2", {16'h0, mem_a}, 32'h41);
    step();
    chk_word("redir_first", 16'h0040);
    step();
    chk_word("redir_second", 16'h0041);

    // enable low for three cycles
    enable = 1'b0;
    step();
    chk_word("en_inflight", 16'h0042);
    step();
    chk("en_empty", {31'h0, inst_valid}, 32'h0);
    chk("en_pc_hold", {16'h0, mem_a}, 32'h43);
    step();
    enable = 1'b1;
    chk("en_empty2", {31'h0, inst_valid}, 32'h0);
    chk("en_pc_hold2", {16'h0, mem_a}, 32'h43);
    step();
    chk("en_empty3", {31'h0, inst_valid}, 32'h0);
    chk("en_pc_run", {16'h0, mem_a}, 32'h44);
    step();
    chk_word("en_resume", 16'h0043);
    step();
    chk_word("en_resume2", 16'h0044);

    // asynchronous reset with a full FIFO
    inst_ready = 1'b0;
    step(); step();
    chk("pre_rst_valid", {31'h0, inst_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_pc", {16'h0, inst_pc}, 32'h0);
    chk("arst_mem_a", {16'h0, mem_a}, 32'h0);
    step();
    rst = 1'b0; inst_ready = 1'b1;
    step();
    chk("rerun_lat", {31'h0, inst_valid}, 32'h0);
    step();
    chk_word("rerun_first", 16'h0000);
    step();
    chk_word("rerun_second", 16'h0001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
